// File: rtl/shift_pkg.sv
// Shared definitions for the multi-cycle shift unit: widths, op codes,
// FSM state encodings and the per-step shift limit.
package shift_pkg;

  localparam int DATA_W  = 64;
  localparam int SHAMT_W = 6;

  localparam logic [1:0] OP_LSL = 2'b00;
  localparam logic [1:0] OP_LSR = 2'b01;
  localparam logic [1:0] OP_ASR = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [1:0] STEP_MAX = 2'd3;

endpackage

// File: rtl/shift_if.sv
// Request/response bundle between the ALU control FSM (master) and the
// shift sequencer (slave).
interface shift_if;
  import shift_pkg::*;

  logic               start;
  logic [1:0]         op;
  logic [DATA_W-1:0]  din;
  logic [SHAMT_W-1:0] shamt;
  logic [DATA_W-1:0]  dout;
  logic               busy;
  logic               done;

  modport master (output start, op, din, shamt, input dout, busy, done);
  modport slave  (input start, op, din, shamt, output dout, busy, done);

endinterface

// File: rtl/shift_step.sv
// Single-step combinational shifter: applies op by 0..3 bit positions.
module shift_step
  import shift_pkg::*;
(
  input  logic [DATA_W-1:0] din,
  input  logic [1:0]        op,
  input  logic [1:0]        step,
  output logic [DATA_W-1:0] dout
);

  // select the shifted operand for the requested op
  always_comb begin
    dout = din;
    case (op)
      OP_LSL:  dout = din << step;
      OP_LSR:  dout = din >> step;
      OP_ASR:  dout = $signed(din) >>> step;
      default: dout = DATA_W'({din, din} >> step);
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle 64-bit shifter: reaches any shift amount 0..63 in steps of at
// most three positions, one step per clock, with start/busy/done handshake.
// Optional feature macro: SHIFT_ROR_EN (op=11 rotates right when defined,
// otherwise op=11 returns the operand unchanged after one cycle).
//
// state   | meaning
// S_IDLE  | waiting for start; latches operand, op and amount
// S_SHIFT | applying one step per clock until the amount is used up
// S_DONE  | one-cycle done pulse, dout holds the result
module shift_sequencer
  import shift_pkg::*;
(
  input  logic    clk,
  input  logic    reset_n,
  shift_if.slave  bus
);

  logic [1:0]         state;
  logic [1:0]         op_q;
  logic [SHAMT_W-1:0] rem;
  logic [DATA_W-1:0]  dout_q;
  logic [1:0]         step;
  logic [DATA_W-1:0]  step_out;
  logic               op_illegal;

`ifdef SHIFT_ROR_EN
  assign op_illegal = 1'b0;
`else
  assign op_illegal = (bus.op == OP_ROR);
`endif

  // step = min(rem, STEP_MAX)
  always_comb begin
    step = STEP_MAX;
    if (rem <= {{(SHAMT_W-2){1'b0}}, STEP_MAX}) step = rem[1:0];
  end

  shift_step u_step (
    .din  (dout_q),
    .op   (op_q),
    .step (step),
    .dout (step_out)
  );

  // sequencing FSM, remaining-count and result register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      op_q   <= OP_LSL;
      rem    <= '0;
      dout_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            dout_q <= bus.din;
            op_q   <= bus.op;
            if (op_illegal || bus.shamt == '0) begin
              rem   <= '0;
              state <= S_DONE;
            end else begin
              rem   <= bus.shamt;
              state <= S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          dout_q <= step_out;
          rem    <= rem - {{(SHAMT_W-2){1'b0}}, step};
          if (rem == {{(SHAMT_W-2){1'b0}}, step}) state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.dout = dout_q;
  assign bus.busy = (state == S_SHIFT);
  assign bus.done = (state == S_DONE);

endmodule
